// File: rtl/imem_loader_if.sv
// imem_loader_if: program-load stream and instruction read port for imem_loader.
//   load_start  - one-cycle request to begin or restart a program load
//   in_valid    - in_byte holds a program byte
//   in_byte     - program byte stream, LSB of each word first
//   in_last     - in_byte is the final byte of the program
//   in_ready    - loader accepts in_byte this cycle
//   load_done   - program loaded, read port valid
//   load_err    - load aborted (misaligned program or overflow)
//   word_count  - words written since the last load_start
//   address     - byte address for instruction read
//   instruction - word read at address (0 when not readable)
//   addr_err    - address misaligned or out of bounds
interface imem_loader_if #(
  parameter int MEM_SIZE = 1024
);
  localparam int WCW = $clog2(MEM_SIZE / 4) + 1;

  logic           load_start;
  logic           in_valid;
  logic [7:0]     in_byte;
  logic           in_last;
  logic           in_ready;
  logic           load_done;
  logic           load_err;
  logic [WCW-1:0] word_count;
  logic [63:0]    address;
  logic [31:0]    instruction;
  logic           addr_err;

  modport master (
    output load_start, in_valid, in_byte, in_last, address,
    input  in_ready, load_done, load_err, word_count, instruction, addr_err
  );

  modport slave (
    input  load_start, in_valid, in_byte, in_last, address,
    output in_ready, load_done, load_err, word_count, instruction, addr_err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words,
// stores them in an instruction memory and serves combinational reads.
//   clk   - single clock, all state on posedge
//   reset - synchronous, active-high; wins over load_start
//   bus   - imem_loader_if.slave (load stream, status, read port)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | after reset, waiting for load_start
// LOAD  | accepting program bytes (in_ready = 1)
// RUN   | program loaded, read port serves written words
// ERR   | load aborted (misaligned last byte or memory overflow)
module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam int MEM_WORDS = MEM_SIZE / 4;
  localparam int IDXW      = $clog2(MEM_WORDS);
  localparam int WCW       = IDXW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_load_done;
  logic            r_load_err;
  logic [WCW-1:0]  r_word_count;
  logic [1:0]      r_byte_idx;
  logic [23:0]     r_asm;
  logic [31:0]     r_mem [MEM_WORDS];

  logic            w_accept;
  logic            w_full;
  logic            w_wr_en;
  logic [31:0]     w_wr_word;
  logic            w_addr_err;
  logic            w_rd_hit;

  // r_in_ready is set exactly while in LOAD, so it doubles as the state qualifier.
  assign w_accept  = r_in_ready && bus.in_valid;
  assign w_full    = (r_word_count == WCW'(MEM_WORDS));
  assign w_wr_word = {bus.in_byte, r_asm};
  assign w_wr_en   = w_accept && !reset && !bus.load_start &&
                     (r_byte_idx == 2'd3) && !w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'h0;
    end else if (bus.load_start) begin
      r_state      <= LOAD;
      r_in_ready   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= '0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'h0;
    end else if (w_accept) begin
      if (r_byte_idx == 2'd3) begin
        r_byte_idx <= 2'd0;
        r_asm      <= 24'h0;
        if (w_full) begin
          // Overflow: no write, word_count stays at MEM_WORDS.
          r_state    <= ERR;
          r_in_ready <= 1'b0;
          r_load_err <= 1'b1;
        end else begin
          r_word_count <= r_word_count + WCW'(1);
          if (bus.in_last) begin
            r_state     <= RUN;
            r_in_ready  <= 1'b0;
            r_load_done <= 1'b1;
          end
        end
      end else if (bus.in_last) begin
        // Program ended mid-word: partial word is dropped.
        r_state    <= ERR;
        r_in_ready <= 1'b0;
        r_load_err <= 1'b1;
      end else begin
        case (r_byte_idx)
          2'd0:    r_asm[7:0]   <= bus.in_byte;
          2'd1:    r_asm[15:8]  <= bus.in_byte;
          default: r_asm[23:16] <= bus.in_byte;
        endcase
        r_byte_idx <= r_byte_idx + 2'd1;
      end
    end
  end

  // Memory kept out of the reset block so it maps onto a plain RAM;
  // stale contents are hidden by the word_count bound on reads.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_word_count[IDXW-1:0]] <= w_wr_word;
    end
  end

  // 65-bit sum so address + 3 cannot wrap past zero.
  assign w_addr_err = (bus.address[1:0] != 2'b00) ||
                      (({1'b0, bus.address} + 65'd3) >= 65'(MEM_SIZE));
  assign w_rd_hit   = (r_state == RUN) && !w_addr_err &&
                      (bus.address[63:2] < 62'(r_word_count));

  assign bus.in_ready    = r_in_ready;
  assign bus.load_done   = r_load_done;
  assign bus.load_err    = r_load_err;
  assign bus.word_count  = r_word_count;
  assign bus.addr_err    = w_addr_err;
  assign bus.instruction = w_rd_hit ? r_mem[bus.address[IDXW+1:2]] : 32'h0;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized stimulus for imem_loader, checked
// every cycle against a queue/array based model of the loader's behaviour.
module tb_imem_loader;
  localparam int MEM_SIZE = 1024;
  localparam int MW       = MEM_SIZE / 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;

  logic clk = 1'b0;
  logic reset;

  imem_loader_if #(.MEM_SIZE(MEM_SIZE)) bus ();
  imem_loader #(.MEM_SIZE(MEM_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  int          m_mode = M_IDLE;
  int          m_words = 0;
  logic [7:0]  m_part[$];
  logic [31:0] m_mem [MW];

  logic [7:0]  stream [0:MW*4+3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit ls, input bit rst, input bit v,
                              input logic [7:0] b, input bit last);
    if (rst) begin
      m_mode = M_IDLE; m_words = 0; m_part.delete();
    end else if (ls) begin
      m_mode = M_LOAD; m_words = 0; m_part.delete();
    end else if (m_mode == M_LOAD && v) begin
      m_part.push_back(b);
      if (m_part.size() == 4) begin
        if (m_words == MW) begin
          m_mode = M_ERR;
        end else begin
          m_mem[m_words] = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_words++;
          if (last) m_mode = M_RUN;
        end
        m_part.delete();
      end else if (last) begin
        m_mode = M_ERR;
      end
    end
  endtask

  function automatic bit exp_aerr(input logic [63:0] a);
    return (a % 4 != 0) || (a > 64'(MEM_SIZE - 4));
  endfunction

  function automatic logic [31:0] exp_instr(input logic [63:0] a);
    if (m_mode != M_RUN || exp_aerr(a)) return 32'h0;
    if (a / 4 >= 64'(m_words)) return 32'h0;
    return m_mem[int'(a / 4)];
  endfunction

  function automatic logic [63:0] pick_addr();
    case ($urandom % 8)
      0: return 64'($urandom % MW) * 4;
      1: return 64'($urandom % 64) * 4 + 64'(1 + $urandom % 3);
      2: return 64'd1020;
      3: return 64'd1021;
      4: return 64'hFFFF_FFFF_FFFF_FFFC;
      5: return {$urandom, $urandom};
      6: return 64'd1024;
      default: return 64'($urandom % 8) * 4;
    endcase
  endfunction

  task automatic step(input bit ls, input bit rst, input bit v,
                      input logic [7:0] b, input bit last, input logic [63:0] a);
    bus.load_start = ls;
    reset          = rst;
    bus.in_valid   = v;
    bus.in_byte    = b;
    bus.in_last    = last;
    bus.address    = a;
    @(posedge clk);
    model_update(ls, rst, v, b, last);
    #1;
    chk("in_ready",    bus.in_ready,    64'(m_mode == M_LOAD));
    chk("load_done",   bus.load_done,   64'(m_mode == M_RUN));
    chk("load_err",    bus.load_err,    64'(m_mode == M_ERR));
    chk("word_count",  bus.word_count,  64'(m_words));
    chk("addr_err",    bus.addr_err,    64'(exp_aerr(a)));
    chk("instruction", bus.instruction, 64'(exp_instr(a)));
  endtask

  task automatic idle_step(input logic [63:0] a);
    step(0, 0, 0, 8'($urandom), 1'($urandom), a);
  endtask

  task automatic send(input int n, input bit last_end, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) idle_step(pick_addr());
      step(0, 0, 1, stream[i], last_end && (i == n - 1), pick_addr());
    end
  endtask

  task automatic load_const(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    stream[0] = b0; stream[1] = b1; stream[2] = b2; stream[3] = b3;
  endtask

  initial begin
    bus.load_start = 0; bus.in_valid = 0; bus.in_byte = 0; bus.in_last = 0;
    bus.address = 0; reset = 1;
    #2;
    step(0, 1, 0, 0, 0, 64'd0);
    step(0, 1, 1, 8'hAA, 0, 64'd0);
    idle_step(64'd0);

    // Two-word program
    load_const(8'h13, 8'h00, 8'h80, 8'hD2);
    stream[4] = 8'h01; stream[5] = 8'h04; stream[6] = 8'h00; stream[7] = 8'h91;
    step(1, 0, 1, 8'hEE, 0, 64'd0);   // byte with load_start must be ignored
    send(8, 1, -1, 0);
    chk("r031_done", bus.load_done, 64'd1);
    chk("r031_wc", bus.word_count, 64'd2);
    idle_step(64'd0); chk("r031_a0", bus.instruction, 64'hD280_0013);
    idle_step(64'd4); chk("r031_a4", bus.instruction, 64'h9100_0401);
    idle_step(64'd8); chk("r031_a8", bus.instruction, 64'h0);
    step(0, 0, 1, 8'h55, 1, 64'd0);   // in_valid ignored in RUN

    // Same stream with a 3-cycle valid gap between bytes 1 and 2
    step(1, 0, 0, 0, 0, 64'd0);
    send(8, 1, 2, 3);
    idle_step(64'd4); chk("r032_a4", bus.instruction, 64'h9100_0401);

    // Misaligned end on byte index 1 of the second word
    step(1, 0, 0, 0, 0, 64'd0);
    send(6, 1, -1, 0);
    chk("r033_err", bus.load_err, 64'd1);
    chk("r033_wc", bus.word_count, 64'd1);
    idle_step(64'd0); chk("r033_a0", bus.instruction, 64'h0);
    step(0, 0, 1, 8'h12, 0, 64'd4);   // ERR ignores in_valid
    step(1, 0, 0, 0, 0, 64'd0);
    chk("r033_ready", bus.in_ready, 64'd1);
    chk("r033_noerr", bus.load_err, 64'd0);

    // Overflow: 257 words
    for (int i = 0; i < MW * 4 + 4; i++) stream[i] = 8'($urandom);
    send(MW * 4 + 4, 0, -1, 0);
    chk("r034_err", bus.load_err, 64'd1);
    chk("r034_wc", bus.word_count, 64'(MW));

    // Exactly full program, then boundary reads
    step(1, 0, 0, 0, 0, 64'd0);
    send(MW * 4, 1, 100, 2);
    chk("full_done", bus.load_done, 64'd1);
    idle_step(64'd1020);
    chk("a1020", bus.instruction,
        64'({stream[1023], stream[1022], stream[1021], stream[1020]}));
    idle_step(64'd2);    chk("a2_err", bus.addr_err, 64'd1); chk("a2_ins", bus.instruction, 64'h0);
    idle_step(64'd1021); chk("a1021_err", bus.addr_err, 64'd1);
    idle_step(64'hFFFF_FFFF_FFFF_FFFC); chk("amax_err", bus.addr_err, 64'd1);

    // Reset mid-load, then fresh one-word load
    step(1, 0, 0, 0, 0, 64'd0);
    for (int i = 0; i < 8; i++) stream[i] = 8'($urandom);
    send(5, 0, -1, 0);
    step(0, 1, 1, 8'h77, 0, 64'd0);
    chk("r036_wc0", bus.word_count, 64'd0);
    step(1, 1, 0, 0, 0, 64'd0);   // reset wins over load_start
    chk("rst_wins", bus.in_ready, 64'd0);
    step(1, 0, 0, 0, 0, 64'd0);
    load_const(8'h00, 8'h00, 8'h00, 8'h14);
    send(4, 1, -1, 0);
    chk("r036_wc", bus.word_count, 64'd1);
    idle_step(64'd0); chk("r036_a0", bus.instruction, 64'h1400_0000);
    idle_step(64'd4); chk("r036_a4", bus.instruction, 64'h0);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      bit v;
      v = ($urandom % 4) != 0;
      step(($urandom % 50) == 0, ($urandom % 400) == 0, v, 8'($urandom),
           v ? (($urandom % 10) == 0) : 1'($urandom), pick_addr());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
